wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
- Write-back end of the pipeline. Holds the MEM/WB pipeline register and waits for variable-latency load data.
- Produces the register-file write interface consumed by the decode stage: RegWriteW, wb_addr, wb_data.
- Asserts stall upstream while a load is outstanding. Counts retired instructions.

Parameters:
- LOAD_TIMEOUT, 16: max cycles spent in LOAD_WAIT before the load is abandoned (range 1..255).
- CNT_W, 32: width of retire_cnt.

Ports:
- CLK  in  1  clock, all state updates on rising edge
- RST_N  in  1  reset; one clock; reset is asynchronous and active-low
- validM  in  1  MEM stage presents a real instruction
- RegWriteM  in  1  instruction writes a register
- MemtoRegM  in  1  instruction is a load; result comes from load_rdata
- WriteRegM  in  5  destination register number
- ALUOutM  in  32  ALU result (non-load write data)
- load_rvalid  in  1  data memory returns load data this cycle
- load_rdata  in  32  load data, valid with load_rvalid
- flushW  in  1  kill incoming/outstanding instruction
- stallW_out  out  1  upstream must hold MEM outputs
- RegWriteW  out  1  register-file write enable, one-cycle pulse
- wb_addr  out  5  register-file write address
- wb_data  out  32  register-file write data
- load_err  out  1  sticky: a load timed out
- retire_cnt  out  CNT_W  retired instruction count

Behaviour:
- Reset (async, RST_N=0): state=RUN, RegWriteW=0, wb_addr=0, wb_data=0, load_err=0, retire_cnt=0, timeout counter=0. stallW_out=0. Applies immediately, including mid-LOAD_WAIT; the outstanding load is dropped.
- stallW_out = (state==LOAD_WAIT) && !flushW. It is combinational from state.
- RegWriteW, wb_addr and wb_data are registered. RegWriteW is 0 on every edge that does not explicitly set it.
- RUN, edge with validM=1, flushW=0:
  - Non-load (MemtoRegM=0): RegWriteW <= RegWriteM && (WriteRegM!=0); wb_addr <= WriteRegM; wb_data <= ALUOutM; retire_cnt++. Stay in RUN. Latency is 1 edge.
  - Load (MemtoRegM=1): latch WriteRegM and RegWriteM; RegWriteW <= 0; timeout counter <= 0; go to LOAD_WAIT.
- RUN with validM=0 or flushW=1: no write, no count. RegWriteW <= 0.
- LOAD_WAIT, each edge, in priority order:
  1. flushW=1: go to RUN, no write, no count. flushW wins over a simultaneous load_rvalid.
  2. load_rvalid=1: RegWriteW <= latched RegWrite && (latched addr!=0); wb_addr <= latched addr; wb_data <= load_rdata; retire_cnt++; go to RUN.
  3. timeout counter == LOAD_TIMEOUT-1: load_err <= 1; no write, no count; go to RUN.
  4. Otherwise: timeout counter++.
- MEM inputs are ignored in LOAD_WAIT. Upstream holds them because of stallW_out. The instruction presented on the edge that leaves LOAD_WAIT is not captured; it is captured on the following edge once the stage is back in RUN.
- load_rvalid in RUN is ignored.
- Writes to register 0 are suppressed (RegWriteW=0) but still count as retired.
- retire_cnt wraps modulo 2^CNT_W.
- load_err clears only on reset.

Optional Feature:
- Macro WB_TRACE_EN.
- Defined: every edge with RegWriteW rising to 1 executes $display("WB: r%0d <= %h", wb_addr, wb_data). Every timeout executes $display("WB: load timeout r%0d").
- Undefined: no display statements are compiled. Logic is otherwise identical.

Test Plan:
1. Non-load retire: validM=1, RegWriteM=1, MemtoRegM=0, WriteRegM=8, ALUOutM=0x00000005 -> next edge RegWriteW=1, wb_addr=8, wb_data=0x00000005, retire_cnt=1. The edge after that: RegWriteW=0.
2. Load, latency 3: load to r9 -> stallW_out=1 for 3 cycles. load_rvalid=1 with load_rdata=0xDEADBEEF -> RegWriteW=1, wb_addr=9, wb_data=0xDEADBEEF. stallW_out=0 afterwards.
3. $zero guard: non-load to r0 with ALUOutM=0x1234 -> RegWriteW stays 0; retire_cnt increments by 1.
4. Flush vs data: in LOAD_WAIT, flushW=1 and load_rvalid=1 on the same edge -> RegWriteW=0, state RUN, retire_cnt unchanged.
5. Timeout, LOAD_TIMEOUT=4: load with no load_rvalid -> after 4 edges in LOAD_WAIT, load_err=1, stallW_out=0, no write. A later load_rvalid is ignored.
6. Async reset mid-wait: RST_N low between edges during LOAD_WAIT -> stallW_out=0 and all outputs 0 immediately. After release, an ALU write to r3 retires normally with retire_cnt=1.

Source files
------------

// File: rtl/wb_stage.sv
// wb_stage: MEM/WB register, load-data wait with timeout, retire counter.
// Ports: CLK, RST_N, MEM inputs (validM, RegWriteM, MemtoRegM, WriteRegM,
//   ALUOutM), load_rvalid/load_rdata, flushW; outputs stallW_out,
//   RegWriteW/wb_addr/wb_data, load_err, retire_cnt.
// Optional: define WB_TRACE_EN to print write-back and timeout traces.
module wb_stage #(
   parameter int LOAD_TIMEOUT = 16,
   parameter int CNT_W        = 32
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             validM,
   input  logic             RegWriteM,
   input  logic             MemtoRegM,
   input  logic [4:0]       WriteRegM,
   input  logic [31:0]      ALUOutM,
   input  logic             load_rvalid,
   input  logic [31:0]      load_rdata,
   input  logic             flushW,
   output logic             stallW_out,
   output logic             RegWriteW,
   output logic [4:0]       wb_addr,
   output logic [31:0]      wb_data,
   output logic             load_err,
   output logic [CNT_W-1:0] retire_cnt
);

   localparam logic [0:0] S_RUN       = 1'b0;
   localparam logic [0:0] S_LOAD_WAIT = 1'b1;

   localparam logic [7:0] TO_LAST = 8'(LOAD_TIMEOUT - 1);

   logic [0:0] state;
   logic [7:0] to_cnt;
   logic [4:0] ld_addr;
   logic       ld_we;

   assign stallW_out = (state == S_LOAD_WAIT) && !flushW;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state      <= S_RUN;
         to_cnt     <= '0;
         ld_addr    <= '0;
         ld_we      <= 1'b0;
         RegWriteW  <= 1'b0;
         wb_addr    <= '0;
         wb_data    <= '0;
         load_err   <= 1'b0;
         retire_cnt <= '0;
      end else begin
         RegWriteW <= 1'b0;
         unique case (state)
            S_RUN: begin
               if (validM && !flushW) begin
                  if (MemtoRegM) begin
                     ld_addr <= WriteRegM;
                     ld_we   <= RegWriteM;
                     to_cnt  <= '0;
                     state   <= S_LOAD_WAIT;
                  end else begin
                     RegWriteW  <= RegWriteM && (WriteRegM != 5'd0);
                     wb_addr    <= WriteRegM;
                     wb_data    <= ALUOutM;
                     retire_cnt <= retire_cnt + 1'b1;
`ifdef WB_TRACE_EN
                     if (RegWriteM && (WriteRegM != 5'd0))
                        $display("WB: r%0d <= %h", WriteRegM, ALUOutM);
`endif
                  end
               end
            end
            S_LOAD_WAIT: begin
               // The instruction presented while leaving is held
               // upstream and captured on the next edge in RUN.
               if (flushW) begin
                  state <= S_RUN;
               end else if (load_rvalid) begin
                  RegWriteW  <= ld_we && (ld_addr != 5'd0);
                  wb_addr    <= ld_addr;
                  wb_data    <= load_rdata;
                  retire_cnt <= retire_cnt + 1'b1;
                  state      <= S_RUN;
`ifdef WB_TRACE_EN
                  if (ld_we && (ld_addr != 5'd0))
                     $display("WB: r%0d <= %h", ld_addr, load_rdata);
`endif
               end else if (to_cnt == TO_LAST) begin
                  load_err <= 1'b1;
                  state    <= S_RUN;
`ifdef WB_TRACE_EN
                  $display("WB: load timeout r%0d", ld_addr);
`endif
               end else begin
                  to_cnt <= to_cnt + 8'd1;
               end
            end
            default: state <= S_RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed checks of wb_stage with LOAD_TIMEOUT=4.
// Inputs change 1 ns after the rising edge; outputs sampled there too.
module tb_wb_stage;

   logic        CLK = 1'b0;
   logic        RST_N;
   logic        validM, RegWriteM, MemtoRegM;
   logic [4:0]  WriteRegM;
   logic [31:0] ALUOutM;
   logic        load_rvalid;
   logic [31:0] load_rdata;
   logic        flushW;
   logic        stallW_out, RegWriteW, load_err;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic [31:0] retire_cnt;

   int n_chk = 0;
   int n_err = 0;

   wb_stage #(.LOAD_TIMEOUT(4), .CNT_W(32)) dut (
      .CLK(CLK), .RST_N(RST_N),
      .validM(validM), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
      .WriteRegM(WriteRegM), .ALUOutM(ALUOutM),
      .load_rvalid(load_rvalid), .load_rdata(load_rdata),
      .flushW(flushW), .stallW_out(stallW_out),
      .RegWriteW(RegWriteW), .wb_addr(wb_addr), .wb_data(wb_data),
      .load_err(load_err), .retire_cnt(retire_cnt)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle();
      validM = 0; RegWriteM = 0; MemtoRegM = 0;
      WriteRegM = 0; ALUOutM = 0;
      load_rvalid = 0; load_rdata = 0; flushW = 0;
   endtask

   task automatic issue(input logic ld, input logic [4:0] rd,
                        input logic [31:0] v);
      validM = 1; RegWriteM = 1; MemtoRegM = ld;
      WriteRegM = rd; ALUOutM = v;
   endtask

   initial begin
      idle();
      RST_N = 0;
      #12;
      check("rst_stall", 32'(stallW_out), 0);
      check("rst_we", 32'(RegWriteW), 0);
      check("rst_addr", 32'(wb_addr), 0);
      check("rst_data", wb_data, 0);
      check("rst_err", 32'(load_err), 0);
      check("rst_cnt", retire_cnt, 0);
      RST_N = 1;
      step();

      // 1: ALU write to r8
      issue(0, 8, 32'h5);
      step();
      idle();
      check("t1_we", 32'(RegWriteW), 1);
      check("t1_addr", 32'(wb_addr), 8);
      check("t1_data", wb_data, 32'h5);
      check("t1_cnt", retire_cnt, 1);
      step();
      check("t1_we_off", 32'(RegWriteW), 0);

      // 2: load to r9, data after 3 stalled cycles
      issue(1, 9, 32'h0);
      step();
      idle();
      check("t2_stall0", 32'(stallW_out), 1);
      check("t2_we0", 32'(RegWriteW), 0);
      step();
      check("t2_stall1", 32'(stallW_out), 1);
      step();
      check("t2_stall2", 32'(stallW_out), 1);
      load_rvalid = 1; load_rdata = 32'hDEADBEEF;
      step();
      load_rvalid = 0; load_rdata = 0;
      check("t2_we", 32'(RegWriteW), 1);
      check("t2_addr", 32'(wb_addr), 9);
      check("t2_data", wb_data, 32'hDEADBEEF);
      check("t2_stall_off", 32'(stallW_out), 0);
      check("t2_cnt", retire_cnt, 2);

      // 3: write to r0 suppressed but retired
      issue(0, 0, 32'h1234);
      step();
      idle();
      check("t3_we", 32'(RegWriteW), 0);
      check("t3_cnt", retire_cnt, 3);

      // 4: flush beats simultaneous load data
      issue(1, 5, 32'h0);
      step();
      idle();
      check("t4_stall", 32'(stallW_out), 1);
      flushW = 1;
      #1;
      check("t4_stall_flush", 32'(stallW_out), 0);
      load_rvalid = 1; load_rdata = 32'hCAFEF00D;
      step();
      idle();
      check("t4_we", 32'(RegWriteW), 0);
      check("t4_run", 32'(stallW_out), 0);
      check("t4_cnt", retire_cnt, 3);

      // 5: timeout after 4 edges in LOAD_WAIT
      issue(1, 6, 32'h0);
      step();
      idle();
      for (int i = 0; i < 3; i++) begin
         check("t5_wait_stall", 32'(stallW_out), 1);
         check("t5_wait_err", 32'(load_err), 0);
         step();
      end
      check("t5_last_stall", 32'(stallW_out), 1);
      step();
      check("t5_err", 32'(load_err), 1);
      check("t5_stall", 32'(stallW_out), 0);
      check("t5_we", 32'(RegWriteW), 0);
      load_rvalid = 1; load_rdata = 32'h11111111;
      step();
      load_rvalid = 0;
      check("t5_late_we", 32'(RegWriteW), 0);
      check("t5_late_cnt", retire_cnt, 3);
      check("t5_err_sticky", 32'(load_err), 1);

      // 6: async reset during LOAD_WAIT
      issue(1, 7, 32'h0);
      step();
      idle();
      check("t6_stall", 32'(stallW_out), 1);
      #2 RST_N = 0;
      #1;
      check("t6_rst_stall", 32'(stallW_out), 0);
      check("t6_rst_we", 32'(RegWriteW), 0);
      check("t6_rst_addr", 32'(wb_addr), 0);
      check("t6_rst_data", wb_data, 0);
      check("t6_rst_err", 32'(load_err), 0);
      check("t6_rst_cnt", retire_cnt, 0);
      #2 RST_N = 1;
      step();
      check("t6_post_stall", 32'(stallW_out), 0);
      issue(0, 3, 32'hA5);
      step();
      idle();
      check("t6_we", 32'(RegWriteW), 1);
      check("t6_addr", 32'(wb_addr), 3);
      check("t6_data", wb_data, 32'hA5);
      check("t6_cnt", retire_cnt, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
